ascon_result_capture: RTL and testbench

- Downstream stage of the serial Ascon core, in the same clock domain.
- Deserialises the core's serial ciphertext/plaintext stream and serial tag stream into parallel words.
- On the core's ready strobe, latches one result and presents it on a valid/ready interface to the host-side logic.
- In decrypt mode, compares the received tag against an expected tag and reports pass/fail.

---
 rtl/ascon_cap_pkg.sv | 13 +
 rtl/ascon_sipo.sv | 30 +++
 rtl/ascon_result_capture.sv | 182 ++++++++++++++++++
 tb/tb_ascon_result_capture.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ascon_cap_pkg.sv
// rtl/ascon_cap_pkg.sv - shared state encoding and default widths for the Ascon result capture stage
package ascon_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } cap_state_t;

    localparam int ASCON_DATA_W = 128;
    localparam int ASCON_TAG_W  = 128;

endpackage

// File: rtl/ascon_sipo.sv
// rtl/ascon_sipo.sv - generic serial-in/parallel-out shifter with clear and enable
//
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear to zero (wins over en)
//   en       : shift one bit in at the LSB end (MSB-first stream)
//   sin      : serial input bit
//   q        : parallel word
module ascon_sipo #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         sin,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[W-2:0], sin};
        end
    end

endmodule

// File: rtl/ascon_result_capture.sv
// rtl/ascon_result_capture.sv - deserialises Ascon core output and presents one result on a valid/ready port
//
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start_i, decrypt_i  : start pulse copy and mode (1 = decrypt) sampled with it
//   data_si, tag_si     : serial data / tag from the core, MSB first
//   ready_si            : core done level; its rising edge ends collection
//   exp_tag_i           : expected tag for decrypt comparison
//   res_data_o/res_tag_o: captured words
//   res_valid_o/res_ready_i : result handshake
//   tag_ok_o, short_o   : result qualifiers, meaningful while res_valid_o=1
//   overrun_o           : sticky lost-result flag
//   busy_o              : collection in progress
module ascon_result_capture
    import ascon_cap_pkg::*;
#(
    parameter int DATA_W = ASCON_DATA_W,
    parameter int TAG_W  = ASCON_TAG_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              decrypt_i,
    input  logic              data_si,
    input  logic              tag_si,
    input  logic              ready_si,
    input  logic [TAG_W-1:0]  exp_tag_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic [TAG_W-1:0]  res_tag_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              tag_ok_o,
    output logic              short_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int MAX_W = (DATA_W > TAG_W) ? DATA_W : TAG_W;
    localparam logic [CNT_W:0] MAX_W_C = (CNT_W+1)'(MAX_W);

    cap_state_t state_q, state_d;

    logic              ready_q;
    logic              rdy_rise;
    logic              accept;
    logic              sh_clr, sh_en, cap, ovr_set, mode_ld;
    logic              mode_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W:0]    cnt_inc;
    logic [DATA_W-1:0] dsh;
    logic [TAG_W-1:0]  tsh;
    logic [DATA_W-1:0] cap_data;
    logic [TAG_W-1:0]  cap_tag;
    logic              unused_msb;

    assign rdy_rise = ready_si & ~ready_q;
    assign accept   = res_valid_o & res_ready_i;
    assign busy_o   = (state_q == COLLECT);

    // The capture includes the bit present on the serial inputs in the rdy_rise cycle.
    assign cap_data = {dsh[DATA_W-2:0], data_si};
    assign cap_tag  = {tsh[TAG_W-2:0], tag_si};
    assign unused_msb = ^{dsh[DATA_W-1], tsh[TAG_W-1]};

    // Bits received including the final one; one bit wider so saturation cannot wrap.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

    ascon_sipo #(.W(DATA_W)) u_data_sipo (
        .clk (clk),
        .rst (rst),
        .clr (sh_clr),
        .en  (sh_en),
        .sin (data_si),
        .q   (dsh)
    );

    ascon_sipo #(.W(TAG_W)) u_tag_sipo (
        .clk (clk),
        .rst (rst),
        .clr (sh_clr),
        .en  (sh_en),
        .sin (tag_si),
        .q   (tsh)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_clr  = 1'b0;
        sh_en   = 1'b0;
        cap     = 1'b0;
        ovr_set = 1'b0;
        mode_ld = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = COLLECT;
                    sh_clr  = 1'b1;
                    mode_ld = 1'b1;
                end
            end
            COLLECT: begin
                if (rdy_rise) begin
                    // Capture beats a coincident restart; the lost start is flagged.
                    cap     = 1'b1;
                    sh_en   = 1'b1;
                    ovr_set = start_i;
                    state_d = HOLD;
                end else if (start_i) begin
                    sh_clr  = 1'b1;
                    mode_ld = 1'b1;
                end else begin
                    sh_en   = 1'b1;
                end
            end
            HOLD: begin
                if (accept) begin
                    if (start_i) begin
                        state_d = COLLECT;
                        sh_clr  = 1'b1;
                        mode_ld = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start_i) begin
                    ovr_set = 1'b1;
                end
                if (rdy_rise) begin
                    ovr_set = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q     <= 1'b0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            res_data_o  <= '0;
            res_tag_o   <= '0;
            res_valid_o <= 1'b0;
            tag_ok_o    <= 1'b0;
            short_o     <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            ready_q <= ready_si;
            if (mode_ld) begin
                mode_q <= decrypt_i;
            end
            if (sh_clr) begin
                cnt_q <= '0;
            end else if (sh_en && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (cap) begin
                res_data_o  <= cap_data;
                res_tag_o   <= cap_tag;
                res_valid_o <= 1'b1;
                short_o     <= (cnt_inc < MAX_W_C);
                tag_ok_o    <= mode_q & (cap_tag == exp_tag_i);
            end else if (accept) begin
                res_valid_o <= 1'b0;
            end
            if (ovr_set) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ascon_result_capture.sv
// tb/tb_ascon_result_capture.sv - self-checking bench for ascon_result_capture
module tb_ascon_result_capture;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_i = 1'b0;
    logic         decrypt_i = 1'b0;
    logic         data_si = 1'b0;
    logic         tag_si = 1'b0;
    logic         ready_si = 1'b0;
    logic [127:0] exp_tag_i = '0;
    logic [127:0] res_data_o;
    logic [127:0] res_tag_o;
    logic         res_valid_o;
    logic         res_ready_i = 1'b0;
    logic         tag_ok_o;
    logic         short_o;
    logic         overrun_o;
    logic         busy_o;

    always #5 clk = ~clk;

    ascon_result_capture dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .decrypt_i   (decrypt_i),
        .data_si     (data_si),
        .tag_si      (tag_si),
        .ready_si    (ready_si),
        .exp_tag_i   (exp_tag_i),
        .res_data_o  (res_data_o),
        .res_tag_o   (res_tag_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .tag_ok_o    (tag_ok_o),
        .short_o     (short_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    typedef struct {
        logic         dec;
        int           nbits;
        logic [127:0] data;
        logic [127:0] tag;
        logic [127:0] etag;
        logic         ok;
        logic         shrt;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        logic [127:0] tag;
        logic         ok;
        logic         shrt;
    } exp_t;

    localparam logic [127:0] D = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] T = 128'hA5A5A5A5A5A5A5A55A5A5A5A5A5A5A5A;

    vec_t vecs[5];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic logic [127:0] mask(int n);
        if (n >= 128) return '1;
        return (128'd1 << n) - 128'd1;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic start_op(logic dec, logic [127:0] etag);
        exp_tag_i = etag;
        decrypt_i = dec;
        start_i   = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
    endtask

    task automatic send_bits(vec_t v);
        exp_t e;
        e.data = v.data & mask(v.nbits);
        e.tag  = v.tag & mask(v.nbits);
        e.ok   = v.ok;
        e.shrt = v.shrt;
        sb.push_back(e);
        for (int i = 0; i < v.nbits; i++) begin
            data_si  = v.data[v.nbits-1-i];
            tag_si   = v.tag[v.nbits-1-i];
            ready_si = (i == v.nbits - 1);
            @(negedge clk);
        end
        ready_si = 1'b0;
        data_si  = 1'b0;
        tag_si   = 1'b0;
    endtask

    task automatic check_result(string name);
        exp_t e;
        chk({name, "_valid"}, res_valid_o, 1'b1);
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            chk({name, "_data"}, res_data_o, e.data);
            chk({name, "_tag"}, res_tag_o, e.tag);
            chk({name, "_tag_ok"}, tag_ok_o, e.ok);
            chk({name, "_short"}, short_o, e.shrt);
        end
    endtask

    task automatic accept(string name);
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        chk({name, "_valid_drop"}, res_valid_o, 1'b0);
        chk({name, "_idle"}, busy_o, 1'b0);
    endtask

    initial begin
        logic [127:0] hd, ht;

        vecs[0] = '{1'b0, 128, D, T, T, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 128, D, T, T, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 128, D, T, T ^ 128'd1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 100, D, T, T, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 127, ~D, ~T, (~T) & mask(127), 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_valid", res_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_overrun", overrun_o, 1'b0);
        chk("rst_tag_ok", tag_ok_o, 1'b0);
        chk("rst_short", short_o, 1'b0);
        chk("rst_data", res_data_o, '0);
        chk("rst_tag", res_tag_o, '0);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            start_op(vecs[k].dec, vecs[k].etag);
            chk($sformatf("v%0d_busy", k), busy_o, 1'b1);
            send_bits(vecs[k]);
            check_result($sformatf("v%0d", k));
            accept($sformatf("v%0d", k));
            chk($sformatf("v%0d_overrun", k), overrun_o, 1'b0);
        end

        // Backpressure: second start and ready edge while holding.
        start_op(1'b0, T);
        send_bits(vecs[0]);
        check_result("bp");
        hd = D;
        ht = T;
        for (int c = 0; c < 20; c++) begin
            start_i  = (c == 3);
            ready_si = (c >= 8 && c < 12);
            @(negedge clk);
        end
        start_i  = 1'b0;
        ready_si = 1'b0;
        chk("bp_data_held", res_data_o, hd);
        chk("bp_tag_held", res_tag_o, ht);
        chk("bp_valid_held", res_valid_o, 1'b1);
        chk("bp_overrun", overrun_o, 1'b1);
        accept("bp");

        // Asynchronous reset in the middle of a collection.
        start_op(1'b1, T);
        for (int i = 0; i < 60; i++) begin
            data_si = D[127-i];
            tag_si  = T[127-i];
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_overrun", overrun_o, 1'b0);
        chk("mid_rst_valid", res_valid_o, 1'b0);
        chk("mid_rst_data", res_data_o, '0);
        chk("mid_rst_tag", res_tag_o, '0);
        @(negedge clk);
        rst = 1'b1;
        data_si = 1'b0;
        tag_si  = 1'b0;
        @(negedge clk);
        start_op(1'b1, T);
        send_bits(vecs[1]);
        check_result("post_rst");

        // Back-to-back: accept and restart in the same cycle.
        res_ready_i = 1'b1;
        start_i     = 1'b1;
        decrypt_i   = 1'b0;
        exp_tag_i   = T;
        @(negedge clk);
        res_ready_i = 1'b0;
        start_i     = 1'b0;
        chk("b2b_busy", busy_o, 1'b1);
        chk("b2b_valid_drop", res_valid_o, 1'b0);
        send_bits(vecs[0]);
        check_result("b2b");
        accept("b2b");
        chk("b2b_overrun", overrun_o, 1'b0);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
